sobel_frame_ctrl: RTL and testbench

- Frame-level sequencer for the Sobel edge datapath.
- Pulls pixels from the input FIFO and drives the 3x3 line-buffer window's shift, clear and pixel inputs.
- Captures the window's combinational edge result, zero-forces border pixels, and writes exactly WIDTH*HEIGHT results to the output FIFO in raster order.
- Handles fill, steady-state, flush and back-to-back frames with full FIFO backpressure.

---
 rtl/sobel_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge datapath: feeds a 3x3 window from the input FIFO and
// writes WIDTH*HEIGHT border-masked results in raster order. Define SOBEL_CTRL_STATS_EN for stall_cycles.
module sobel_frame_ctrl #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  win_clear,
  output logic                  win_shift,
  output logic [DATA_WIDTH-1:0] win_pixel,
  input  logic [DATA_WIDTH-1:0] edge_in,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  busy,
  output logic                  frame_done
`ifdef SOBEL_CTRL_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int RW = $clog2(HEIGHT + 1);
  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH);
  localparam logic [31:0]   FILL_LAST  = 32'(WIDTH);
  localparam logic [31:0]   FRAME_LAST = 32'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_t;

  state_t                  state, state_next;
  logic [31:0]             in_cnt;
  logic [FW-1:0]           flush_cnt;
  logic [RW-1:0]           out_row, pend_row;
  logic [CW-1:0]           out_col, pend_col;
  logic                    pend, hold_valid;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_ready, pend_ready, xfer, shift, set_pend, border;

  // Two-stage valid/ready pipe: pend (window centre) -> hold -> output FIFO. A stage accepts
  // when it is empty or is emptying this cycle, so each stage can reload on the cycle it drains.
  assign out_wr_en  = hold_valid && !out_full;
  assign out_din    = hold_data;
  assign hold_ready = !hold_valid || out_wr_en;
  assign pend_ready = !pend || hold_ready;
  assign xfer       = pend && hold_ready;
  assign set_pend   = shift && (state == RUN || state == FLUSH);
  assign border     = (pend_row == '0) || (pend_row == ROW_LAST) ||
                      (pend_col == '0) || (pend_col == COL_LAST);
  assign win_shift  = shift;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!in_empty) state_next = FILL;
      FILL:    if (shift && in_cnt == FILL_LAST) state_next = RUN;
      RUN:     if (shift && in_cnt == FRAME_LAST) state_next = FLUSH;
      FLUSH:   if (shift && flush_cnt == FLUSH_LAST) state_next = DRAIN;
      DRAIN:   if (frame_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // win_clear is masked by reset so every output reads 0 while reset is held.
  always_comb begin
    win_clear  = 1'b0;
    shift      = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    win_clear  = !in_empty && !reset;
      FILL:    shift      = !in_empty;
      RUN:     shift      = !in_empty && pend_ready;
      FLUSH:   shift      = pend_ready;
      DRAIN:   frame_done = !pend && out_wr_en;
      default: ;
    endcase
    in_rd_en  = shift && (state != FLUSH);
    win_pixel = in_rd_en ? in_dout : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_cnt    <= '0;
      flush_cnt <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (state == IDLE) begin
      in_cnt    <= '0;
      flush_cnt <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      if (in_rd_en) in_cnt <= in_cnt + 32'd1;
      if (shift && state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if (set_pend) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  // edge_in is sampled on the transfer cycle, when the window still holds pend's centre.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend       <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (set_pend) begin
        pend     <= 1'b1;
        pend_row <= out_row;
        pend_col <= out_col;
      end else if (xfer) begin
        pend <= 1'b0;
      end
      if (xfer) begin
        hold_data  <= border ? '0 : edge_in;
        hold_valid <= 1'b1;
      end else if (out_wr_en) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef SOBEL_CTRL_STATS_EN
  logic stall_now;
  assign stall_now = (hold_valid && out_full) || (state == RUN && pend_ready && in_empty);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (state == IDLE && state_next == FILL)
      stall_cycles <= '0;
    else if (stall_now && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: FIFO and window stub models, raster scoreboard of expected results,
// directed scenarios with random pixels and random input-FIFO emptiness.
module tb_sobel_frame_ctrl;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int DW   = 8;
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_rd_en, in_empty, win_clear, win_shift, out_wr_en, out_full, busy, frame_done;
  logic [DW-1:0] in_dout, win_pixel, edge_in, out_din;
`ifdef SOBEL_CTRL_STATS_EN
  logic [31:0]   stall_cycles;
`endif

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .win_clear(win_clear), .win_shift(win_shift), .win_pixel(win_pixel),
    .edge_in(edge_in),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .busy(busy), .frame_done(frame_done)
`ifdef SOBEL_CTRL_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // models: input FIFO contents, expected output stream, pixels shifted into the window
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] hist[$];

  int rd_cnt, wr_cnt, clear_cnt, done_cnt, frame_wr, stall_len;
  bit rand_empty, full_force, after_done, prev_clear;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expect_px(input int k, input logic [DW-1:0] p);
    int r, c;
    r = k / W;
    c = k % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return '0;
    return ~p;
  endfunction

  task automatic load_frame();
    logic [DW-1:0] p;
    for (int k = 0; k < NPIX; k++) begin
      p = DW'($urandom);
      fifo_q.push_back(p);
      exp_q.push_back(expect_px(k, p));
    end
  endtask

  // Window stub: centre of the window after n shifts is the pixel shifted W+2 shifts earlier.
  task automatic drive_inputs();
    in_empty = (fifo_q.size() == 0) || (rand_empty && $urandom_range(0, 1) == 1);
    in_dout  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    out_full = full_force;
    edge_in  = (hist.size() >= W + 2) ? ~hist[hist.size() - W - 2] : DW'($urandom);
  endtask

  task automatic zero_counts();
    rd_cnt = 0; wr_cnt = 0; clear_cnt = 0;
  endtask

  task automatic cycle();
    logic [DW-1:0] p;
    @(negedge clock);
    if (after_done) begin
      check("busy_gap", busy, 0);
      if (!in_empty) check("clear_after_done", win_clear, 1);
      after_done = 0;
    end
    if (prev_clear) begin
      check("busy_after_clear", busy, 1);
`ifdef SOBEL_CTRL_STATS_EN
      check("stats_cleared", stall_cycles, 0);
`endif
    end
    if (win_clear) begin
      clear_cnt++;
      hist.delete();
    end
    if (win_shift) hist.push_back(win_pixel);
    if (in_empty) check("rd_while_empty", in_rd_en, 0);
    if (in_rd_en) begin
      rd_cnt++;
      if (fifo_q.size() != 0) begin
        p = fifo_q.pop_front();
        check("win_pixel", win_pixel, p);
      end
    end
    if (win_shift && !in_rd_en) check("flush_pixel", win_pixel, 0);
    if (out_wr_en) begin
      wr_cnt++;
      frame_wr++;
      if (exp_q.size() != 0) check("out_din", out_din, exp_q.pop_front());
      else check("unexpected_write", out_wr_en, 0);
      check("frame_done", frame_done, frame_wr == NPIX);
      if (frame_wr == NPIX) frame_wr = 0;
    end else if (frame_done) begin
      check("done_without_write", frame_done, 0);
    end
    if (frame_done) begin
      done_cnt++;
      after_done = 1;
    end
    if (full_force) begin
      stall_len++;
      check("wr_while_full", out_wr_en, 0);
      if (stall_len > 2) check("rd_during_stall", in_rd_en, 0);
    end else begin
      stall_len = 0;
    end
    prev_clear = win_clear;
    @(posedge clock);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check("frame_timeout", done_cnt, target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_rd_en"}, in_rd_en, 0);
    check({tag, "_win_clear"}, win_clear, 0);
    check({tag, "_win_shift"}, win_shift, 0);
    check({tag, "_win_pixel"}, win_pixel, 0);
    check({tag, "_out_wr_en"}, out_wr_en, 0);
    check({tag, "_out_din"}, out_din, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int n;
    in_empty = 1'b1; in_dout = '0; out_full = 1'b0; edge_in = '0;
    rand_empty = 0; full_force = 0; after_done = 0; prev_clear = 0;
    done_cnt = 0; frame_wr = 0; stall_len = 0;
    zero_counts();
    #1 reset = 1'b1;
    #10;
    check_outputs_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // frame 1: FIFO never empty while pixels remain, no backpressure
    load_frame();
    drive_inputs();
    run_until_done(1, 400);
    check("f1_writes", wr_cnt, NPIX);
    check("f1_reads", rd_cnt, NPIX);
    check("f1_clears", clear_cnt, 1);
    repeat (5) cycle();
    check("f1_done_once", done_cnt, 1);
    check("f1_idle_busy", busy, 0);

    // frame 2: input FIFO randomly empty half the time
    zero_counts();
    rand_empty = 1;
    load_frame();
    drive_inputs();
    run_until_done(2, 1000);
    rand_empty = 0;
    check("f2_writes", wr_cnt, NPIX);
    check("f2_reads", rd_cnt, NPIX);
    check("f2_clears", clear_cnt, 1);

    // frame 3: output FIFO full for 20 cycles mid-RUN
    zero_counts();
    load_frame();
    drive_inputs();
    n = 0;
    while (frame_wr < 15 && n < 400) begin
      cycle();
      n++;
    end
    check("f3_reach_mid_run", frame_wr >= 15, 1);
    full_force = 1;
    out_full = 1'b1;
    repeat (20) cycle();
    full_force = 0;
    out_full = 1'b0;
    run_until_done(3, 400);
    check("f3_writes", wr_cnt, NPIX);
    check("f3_reads", rd_cnt, NPIX);
`ifdef SOBEL_CTRL_STATS_EN
    check("f3_stall_cycles", stall_cycles, 20);
`endif

    // frames 4 and 5 back to back
    zero_counts();
    load_frame();
    load_frame();
    drive_inputs();
    run_until_done(5, 800);
    check("b2b_writes", wr_cnt, 2 * NPIX);
    check("b2b_reads", rd_cnt, 2 * NPIX);
    check("b2b_clears", clear_cnt, 2);

    // reset mid-frame after 20 reads, then a fresh frame
    zero_counts();
    load_frame();
    drive_inputs();
    n = 0;
    while (rd_cnt < 20 && n < 400) begin
      cycle();
      n++;
    end
    check("rst_reach_20_reads", rd_cnt, 20);
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
`ifdef SOBEL_CTRL_STATS_EN
    check("midreset_stall_cycles", stall_cycles, 0);
`endif
    fifo_q.delete();
    exp_q.delete();
    hist.delete();
    frame_wr = 0; after_done = 0; prev_clear = 0; stall_len = 0;
    drive_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    zero_counts();
    load_frame();
    drive_inputs();
    run_until_done(6, 400);
    check("post_reset_writes", wr_cnt, NPIX);
    check("post_reset_reads", rd_cnt, NPIX);
    check("post_reset_clears", clear_cnt, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
